vend_sequencer: RTL

Transaction sequencer for the coffee vending machine. Accumulates coin credit against a configurable price and holds a stock count. Drives the dispenser actuator for a fixed number of cycles, then pays out change one 5-unit coin per cycle. Sits between the coin acceptor and the dispenser/change-hopper hardware, and replaces the bare coin-state FSM as the owner of the vend sequence.

---
 rtl/vend_sequencer_if.sv | 29 ++
 rtl/vend_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/vend_sequencer_if.sv
// Coin-acceptor / dispenser bus for the vend sequencer.
interface vend_sequencer_if;
  localparam int unsigned CREDIT_W = 6;
  localparam int unsigned STOCK_W  = 8;

  logic [1:0]          coin;
  logic                cancel;
  logic                refill;
  logic                disp_on;
  logic                coffee;
  logic                ret5;
  logic                coin_rej;
  logic [CREDIT_W-1:0] credit;
  logic [STOCK_W-1:0]  stock;
  logic                sold_out;
  logic                busy;

  // Coin acceptor / front panel side
  modport master (
    output coin, cancel, refill,
    input  disp_on, coffee, ret5, coin_rej, credit, stock, sold_out, busy
  );

  // Sequencer side
  modport slave (
    input  coin, cancel, refill,
    output disp_on, coffee, ret5, coin_rej, credit, stock, sold_out, busy
  );
endinterface

// File: rtl/vend_sequencer.sv
// Vend transaction sequencer: credit accumulation, dispense timing, change payout, stock.
module vend_sequencer #(
  parameter int unsigned PRICE       = 15,
  parameter int unsigned DISP_CYCLES = 8,
  parameter int unsigned STOCK_INIT  = 10
) (
  input  logic             clk,
  input  logic             rstn,   // active-high asynchronous reset
  vend_sequencer_if.slave  bus
);

  localparam int unsigned CW = 6;
  localparam int unsigned SW = 8;
  localparam int unsigned TW = $clog2(DISP_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    CREDIT,
    DISPENSE,
    CHANGE,
    SOLDOUT
  } state_t;

  state_t         state;
  logic [CW-1:0]  credit_q;
  logic [SW-1:0]  stock_q;
  logic [TW-1:0]  timer_q;
  logic           coin_rej_q;

  logic [CW-1:0]  coin_val;
  logic           coin_ok;
  logic           coin_bad;
  logic [CW-1:0]  credit_sum;
  logic           vend;
  logic [SW-1:0]  stock_d;
  logic           timer_last;

  // Coin decode, vend qualification and next stock value
  always_comb begin
    coin_val   = '0;
    coin_ok    = 1'b0;
    coin_bad   = 1'b0;
    credit_sum = credit_q;
    vend       = 1'b0;
    stock_d    = stock_q;

    case (bus.coin)
      2'b01:   coin_val = CW'(5);
      2'b10:   coin_val = CW'(10);
      default: coin_val = '0;
    endcase

    coin_ok  = ((state == IDLE) || (state == CREDIT)) && (coin_val != '0);
    coin_bad = (bus.coin != 2'b00) && !coin_ok;

    if (coin_ok) credit_sum = credit_q + coin_val;
    vend = coin_ok && (credit_sum >= CW'(PRICE));

    // A refill overrides the decrement of a simultaneous vend
    if (bus.refill)  stock_d = SW'(STOCK_INIT);
    else if (vend)   stock_d = stock_q - SW'(1);

    timer_last = (timer_q == TW'(DISP_CYCLES - 1));
  end

  // Sequencer state, credit, stock, dispense timer and reject pulse
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state      <= IDLE;
      credit_q   <= '0;
      stock_q    <= SW'(STOCK_INIT);
      timer_q    <= '0;
      coin_rej_q <= 1'b0;
    end else begin
      coin_rej_q <= coin_bad;
      stock_q    <= stock_d;

      case (state)
        IDLE: begin
          if (vend) begin
            credit_q <= credit_sum - CW'(PRICE);
            timer_q  <= '0;
            state    <= DISPENSE;
          end else if (coin_ok) begin
            credit_q <= credit_sum;
            state    <= CREDIT;
          end
        end

        CREDIT: begin
          if (vend) begin
            credit_q <= credit_sum - CW'(PRICE);
            timer_q  <= '0;
            state    <= DISPENSE;
          end else if (bus.cancel) begin
            credit_q <= credit_sum;
            state    <= CHANGE;
          end else begin
            credit_q <= credit_sum;
          end
        end

        DISPENSE: begin
          timer_q <= timer_q + TW'(1);
          if (timer_last) begin
            timer_q <= '0;
            if (credit_q != '0)     state <= CHANGE;
            else if (stock_d == '0) state <= SOLDOUT;
            else                    state <= IDLE;
          end
        end

        CHANGE: begin
          if (credit_q <= CW'(5)) begin
            credit_q <= '0;
            state    <= (stock_d == '0) ? SOLDOUT : IDLE;
          end else begin
            credit_q <= credit_q - CW'(5);
          end
        end

        SOLDOUT: begin
          if (bus.refill) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.disp_on  = (state == DISPENSE);
  assign bus.coffee   = (state == DISPENSE) && timer_last;
  assign bus.ret5     = (state == CHANGE);
  assign bus.busy     = (state == DISPENSE) || (state == CHANGE);
  assign bus.sold_out = (state == SOLDOUT);
  assign bus.coin_rej = coin_rej_q;
  assign bus.credit   = credit_q;
  assign bus.stock    = stock_q;

endmodule
